// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with burst integrity and default-master parking.
// Define AHB_ARB_LOCK_EN to honour hlock (LOCKED state, hmastlock); otherwise hlock is ignored.
module ahb_arbiter #(
    parameter int MASTER_NUM     = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MIDX_W         = $clog2(MASTER_NUM)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [MASTER_NUM-1:0] hbusreq,
    input  logic [MASTER_NUM-1:0] hlock,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    input  logic                  hready,
    output logic [MASTER_NUM-1:0] hgrant,
    output logic [MIDX_W-1:0]     hmaster,
    output logic [MIDX_W-1:0]     hmaster_data,
    output logic                  hmastlock
);
    localparam logic [1:0] PARK = 2'd0, OWN = 2'd1, BURST = 2'd2, LOCKED = 2'd3;
    logic [1:0]        state;
    logic [4:0]        cnt, cnt_nx, len_m1;
    logic [MIDX_W-1:0] win, cand;
    logic              found, idle, busy, nonseq, seq, fixed, hold, lock_hold, lock_nx, lock_state;
    assign idle   = htrans == 2'd0;
    assign busy   = htrans == 2'd1;
    assign nonseq = htrans == 2'd2;
    assign seq    = htrans == 2'd3;
    assign fixed  = hburst[2:1] != 2'd0;
    assign len_m1 = hburst[2:1] == 2'd1 ? 5'd3 : hburst[2:1] == 2'd2 ? 5'd7 : 5'd15;
    assign cnt_nx = nonseq ? (fixed ? len_m1 : 5'd0) :
                    seq    ? (cnt != 5'd0 ? cnt - 5'd1 : 5'd0) :
                    busy   ? cnt : 5'd0;
    assign hold = (nonseq && fixed) || (seq && cnt > 5'd1) || (busy && cnt != 5'd0) ||
                  (hburst == 3'd1 && !idle && hbusreq[hmaster]);
`ifdef AHB_ARB_LOCK_EN
    // LOCKED lasts one extra cycle after hlock drops so the unlocked IDLE completes
    assign lock_hold  = hlock[hmaster] || state == LOCKED;
    assign lock_nx    = hlock[hmaster];
    assign lock_state = !hold && hlock[hmaster];
`else
    logic unused_lock;
    assign unused_lock = ^{hlock, state, idle};
    assign lock_hold   = 1'b0;
    assign lock_nx     = 1'b0;
    assign lock_state  = 1'b0;
`endif
    // First requester after the last owner; the owner itself is checked last
    always_comb begin
        win   = MIDX_W'(DEFAULT_MASTER);
        found = 1'b0;
        cand  = '0;
        for (int i = MASTER_NUM; i >= 1; i--) begin
            cand = MIDX_W'((int'(hmaster) + i) % MASTER_NUM);
            if (hbusreq[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= PARK;
            cnt          <= 5'd0;
            hmaster      <= MIDX_W'(DEFAULT_MASTER);
            hmaster_data <= MIDX_W'(DEFAULT_MASTER);
            hgrant       <= MASTER_NUM'(1) << DEFAULT_MASTER;
            hmastlock    <= 1'b0;
        end else if (hready) begin
            cnt          <= cnt_nx;
            hmaster_data <= hmaster;
            hmastlock    <= lock_nx;
            if (!hold && !lock_hold) begin
                hmaster <= win;
                hgrant  <= MASTER_NUM'(1) << win;
                state   <= found ? OWN : PARK;
            end else begin
                state <= cnt_nx != 5'd0 ? BURST : lock_state ? LOCKED : OWN;
            end
        end
    end
endmodule
